// File: rtl/pipe_perf_monitor.sv
// ============================================================================
// Module   : pipe_perf_monitor
// Brief    : Cycle/stall/flush/retire performance counters with snapshot read
//            port. Optional flush-PC trace FIFO enabled by PERF_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30,
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        flush_i,
    input  logic        retire_i,
    input  logic [31:0] pc_i,
    input  logic        snap_i,
    input  logic        rd_req_i,
    input  logic [2:0]  rd_addr_i,
    output logic        rd_ack_o,
    output logic [31:0] rd_data_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(CYCLE_LIMIT);

    state_t             r_state;
    logic               r_done;
    logic [CNT_W-1:0]   r_cyc, r_stall, r_flush, r_ret;
    logic [CNT_W-1:0]   r_sh_cyc, r_sh_stall, r_sh_flush, r_sh_ret;
    logic               r_rd_ack;
    logic [31:0]        r_rd_data;

    logic               w_run;
    logic [CNT_W-1:0]   w_cyc_nxt;
    logic               w_trace_empty;
    logic               w_trace_ovf;
    logic [31:0]        w_trace_head;
    logic [31:0]        w_rd_mux;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign w_run     = (r_state == RUN);
    assign w_cyc_nxt = sat_inc(r_cyc, 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_i) r_state <= RUN;
                RUN: begin
                    if ((CYCLE_LIMIT != 0) && (w_cyc_nxt == C_LIMIT)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Shadows take the pre-edge live values, so same-edge increments are excluded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cyc      <= '0;
            r_stall    <= '0;
            r_flush    <= '0;
            r_ret      <= '0;
            r_sh_cyc   <= '0;
            r_sh_stall <= '0;
            r_sh_flush <= '0;
            r_sh_ret   <= '0;
        end else begin
            if (w_run) begin
                r_cyc   <= w_cyc_nxt;
                r_stall <= sat_inc(r_stall, stall_i & ~branch_i);
                r_flush <= sat_inc(r_flush, flush_i);
                r_ret   <= sat_inc(r_ret, retire_i);
            end
            if (snap_i) begin
                r_sh_cyc   <= r_cyc;
                r_sh_stall <= r_stall;
                r_sh_flush <= r_flush;
                r_sh_ret   <= r_ret;
            end
        end
    end

`ifdef PERF_TRACE_EN
    localparam int AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

    logic [31:0] r_mem [TRACE_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_ovf;
    logic        w_full, w_push, w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_trace_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push        = w_run && flush_i;
    assign w_pop         = rd_req_i && (rd_addr_i == 3'd6) && !w_trace_empty;
    assign w_trace_ovf   = r_ovf;
    assign w_trace_head  = w_trace_empty ? 32'd0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < TRACE_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push) begin
                if (!w_full || w_pop) begin
                    r_mem[r_wr_ptr[AW-1:0]] <= pc_i;
                    r_wr_ptr                <= r_wr_ptr + 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_pc;

    assign w_unused_pc   = ^pc_i;
    assign w_trace_empty = 1'b1;
    assign w_trace_ovf   = 1'b0;
    assign w_trace_head  = 32'd0;
`endif

    always_comb begin
        w_rd_mux = 32'd0;
        case (rd_addr_i)
            3'd0: w_rd_mux = 32'(r_sh_cyc);
            3'd1: w_rd_mux = 32'(r_sh_stall);
            3'd2: w_rd_mux = 32'(r_sh_flush);
            3'd3: w_rd_mux = 32'(r_sh_ret);
            3'd4: w_rd_mux = {27'd0, w_trace_ovf, w_trace_empty, r_done, r_state};
            3'd5: w_rd_mux = 32'(r_cyc);
            3'd6: w_rd_mux = w_trace_head;
            default: w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= 32'd0;
        end else begin
            r_rd_ack <= rd_req_i;
            if (rd_req_i) r_rd_data <= w_rd_mux;
        end
    end

    assign rd_ack_o  = r_rd_ack;
    assign rd_data_o = r_rd_data;
    assign done_o    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pipe_perf_monitor.sv
// ============================================================================
// Module   : tb_pipe_perf_monitor
// Brief    : Scoreboard bench for pipe_perf_monitor (three parameterisations
//            sharing stimulus; trace checks when PERF_TRACE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_perf_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stall, branch, flush, retire, snap;
    logic [31:0] pc;
    logic [2:0]  rd_req;
    logic [2:0]  rd_addr;
    logic [2:0]  rd_ack;
    logic [31:0] rd_data [3];
    logic [2:0]  done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          id;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    // u_a: default limit 30; u_b: unlimited; u_c: 4-bit counters, unlimited
    pipe_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30), .TRACE_DEPTH(8)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .branch_i(branch), .flush_i(flush), .retire_i(retire), .pc_i(pc),
        .snap_i(snap), .rd_req_i(rd_req[0]), .rd_addr_i(rd_addr),
        .rd_ack_o(rd_ack[0]), .rd_data_o(rd_data[0]), .done_o(done[0]));

    pipe_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(0), .TRACE_DEPTH(8)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .branch_i(branch), .flush_i(flush), .retire_i(retire), .pc_i(pc),
        .snap_i(snap), .rd_req_i(rd_req[1]), .rd_addr_i(rd_addr),
        .rd_ack_o(rd_ack[1]), .rd_data_o(rd_data[1]), .done_o(done[1]));

    pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0), .TRACE_DEPTH(8)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .branch_i(branch), .flush_i(flush), .retire_i(retire), .pc_i(pc),
        .snap_i(snap), .rd_req_i(rd_req[2]), .rd_addr_i(rd_addr),
        .rd_ack_o(rd_ack[2]), .rd_data_o(rd_data[2]), .done_o(done[2]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One-cycle read on instance 'inst'; the expectation is scored when the ack arrives.
    task automatic rd(input int inst, input logic [2:0] addr, input logic [31:0] exp, input string tag);
        exp_t e;
        e.id  = inst;
        e.exp = exp;
        e.tag = tag;
        sbq.push_back(e);
        rd_req       = 3'b000;
        rd_req[inst] = 1'b1;
        rd_addr      = addr;
        step();
        rd_req = 3'b000;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        {stall, branch, flush, retire, snap} = 5'b0;
        rd_req = 3'b000;
        step();
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_ack[i]) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ack_instance", 32'(i), 32'(e.id));
                    check(e.tag, rd_data[i], e.exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_status;
        logic [31:0] exp_pop;

        pc      = 32'd0;
        rd_addr = 3'd0;
        do_reset();

        // Phase 1: full run to the cycle limit with mixed hazards
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            stall  = (k < 15);
            branch = (k >= 12) && (k < 15);
            flush  = (k >= 15) && (k < 19);
            retire = (k >= 10);
            pc     = 32'((k - 14) * 4);
            step();
        end
        {stall, flush, retire} = 3'b111;
        branch = 1'b0;
        repeat (3) step();
        {stall, flush, retire} = 3'b000;
        snap = 1'b1;
        step();
        snap = 1'b0;
        check("done_after_limit", 32'(done[0]), 32'd1);
`ifdef PERF_TRACE_EN
        exp_status = 32'd6;
        exp_pop    = 32'h4;
`else
        exp_status = 32'd14;
        exp_pop    = 32'd0;
`endif
        rd(0, 3'd0, 32'd30, "cyc");
        rd(0, 3'd1, 32'd12, "stall");
        rd(0, 3'd2, 32'd4,  "flush");
        rd(0, 3'd3, 32'd20, "retired");
        rd(0, 3'd4, exp_status, "status_done");
        rd(0, 3'd6, exp_pop, "addr6");
        rd(0, 3'd7, 32'd0, "addr7");

        // Phase 2: reset state, then unlimited run with live reads every cycle
        do_reset();
        check("rst_ack", 32'(rd_ack[0]), 32'd0);
        check("rst_data", rd_data[0], 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        start = 1'b1;
        step();
        for (int k = 0; k < 100; k++) rd(1, 3'd5, 32'(k), "live_cyc");
        check("nolimit_done", 32'(done[1]), 32'd0);
        rd(2, 3'd5, 32'd15, "sat_cyc");
        rd(0, 3'd5, 32'd30, "frozen_cyc");

        // Phase 3: snap and read on the same edge
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        snap = 1'b1;
        rd(0, 3'd0, 32'd0, "snap_same_edge");
        snap = 1'b0;
        rd(0, 3'd0, 32'd5, "snap_after");
        rd(0, 3'd5, 32'd7, "live_after_snap");

        // Phase 4: reset mid-run with a read in flight
        do_reset();
        start = 1'b1;
        step();
        repeat (10) step();
        rst        = 1'b1;
        rd_req[0]  = 1'b1;
        rd_addr    = 3'd5;
        start      = 1'b0;
        step();
        check("rst_inflight_ack", 32'(rd_ack[0]), 32'd0);
        rst    = 1'b0;
        rd_req = 3'b000;
        rd(0, 3'd4, 32'd8, "rst_status");
        rd(0, 3'd5, 32'd0, "rst_cyc");

`ifdef PERF_TRACE_EN
        // Phase 5: trace overflow and drain
        do_reset();
        start = 1'b1;
        step();
        flush = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = 32'((i + 1) * 4);
            step();
        end
        flush = 1'b0;
        for (int i = 0; i < 8; i++) rd(0, 3'd6, 32'((i + 1) * 4), "trace_pop");
        rd(0, 3'd6, 32'd0, "trace_pop_empty");
        rd(0, 3'd4, 32'd25, "trace_status");
`endif

        step();
        step();
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
